muldiv_sequencer: RTL

//  Multi-cycle sequencer for the mult (ALU_Control=4'b0101) and div (4'b1011) codes.
//  It holds the HI/LO result registers and runs an iterative shift-add multiply or

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide unit holding the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, sign-corrected on completion.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam logic [3:0] CTL_MULT = 4'b0101;
    localparam logic [3:0] CTL_DIV  = 4'b1011;
    localparam int         CW       = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   operand;
    logic             res_neg;
    logic             rem_neg;
    logic             zero_div;

    logic             is_mult;
    logic             is_div;
    logic             accept;
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH+1:0] mult_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             div_ok;
    logic [WIDTH:0]   next_upper;
    logic [WIDTH-1:0] next_lower;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    always_comb begin
        is_mult = (alu_ctl == CTL_MULT);
        is_div  = (alu_ctl == CTL_DIV);
        accept  = (state == IDLE) && start && (is_mult || is_div);
        stall   = busy | accept;

        // Magnitudes are one bit wider so that the most negative operand stays exact.
        ext_a = {op_a[WIDTH-1], op_a};
        ext_b = {op_b[WIDTH-1], op_b};
        abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
        abs_b = ext_b[WIDTH] ? -ext_b : ext_b;

        mult_sum  = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        div_shift = {upper[WIDTH-1:0], lower[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {1'b0, operand};
        div_ok    = ~div_trial[WIDTH+1];

        if (state == DIV) begin
            next_upper = div_ok ? div_trial[WIDTH:0] : div_shift;
            next_lower = {lower[WIDTH-2:0], div_ok};
        end else begin
            next_upper = mult_sum[WIDTH+1:1];
            next_lower = {mult_sum[0], lower[WIDTH-1:1]};
        end

        prod_raw = {next_upper[WIDTH-1:0], next_lower};
        prod_fix = res_neg ? -prod_raw : prod_raw;

        if (state == DIV) begin
            fix_hi = rem_neg ? -next_upper[WIDTH-1:0] : next_upper[WIDTH-1:0];
            if (zero_div)
                fix_lo = '1;
            else
                fix_lo = res_neg ? -next_lower : next_lower;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // The final iteration writes the sign-corrected result so it is visible throughout FIX.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            upper    <= '0;
            lower    <= '0;
            operand  <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            zero_div <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= is_div ? DIV : MULT;
                        busy     <= 1'b1;
                        count    <= CW'(WIDTH - 1);
                        div_zero <= 1'b0;
                        upper    <= '0;
                        res_neg  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        rem_neg  <= op_a[WIDTH-1];
                        zero_div <= is_div && (op_b == '0);
                        if (is_div) begin
                            lower   <= abs_a[WIDTH-1:0];
                            operand <= abs_b;
                        end else begin
                            lower   <= abs_b[WIDTH-1:0];
                            operand <= abs_a;
                        end
                    end else begin
                        if (hi_we)
                            hi <= wr_data;
                        if (lo_we)
                            lo <= wr_data;
                    end
                end
                MULT, DIV: begin
                    upper <= next_upper;
                    lower <= next_lower;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                        done  <= 1'b1;
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        if (zero_div)
                            div_zero <= 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
